fsub: RTL and testbench

FSUB -- requirements
Module: fsub

---
 rtl/fsub_pkg.sv | 26 ++
 rtl/fsub_lzc.sv | 16 +
 rtl/fsub.sv | 130 +++++++++++++
 tb/tb_fsub.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsub_pkg.sv
// Shared constants and stage-1 pipeline record for the binary32 subtractor.
package fsub_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  // significand plus guard/round/sticky
  localparam int SIG_W = MAN_W + 1;
  localparam int EXT_W = SIG_W + 3;

  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] PINF = 32'h7F800000;
  localparam logic [31:0] NINF = 32'hFF800000;

  // what stage 1 hands to stage 2
  typedef struct packed {
    logic             sgn;      // sign of the larger-magnitude operand
    logic             eff_sub;  // magnitudes were subtracted
    logic [EXP_W-1:0] exp;      // exponent of the larger operand
    logic [EXT_W:0]   sum;      // carry + aligned significand result with GRS
    logic             nan;      // result is NaN
    logic             inf;      // result is infinity from an infinite input
    logic             inf_s;    // sign of that infinity
  } s1_t;
endpackage

// File: rtl/fsub_lzc.sv
// 27-bit leading-zero counter; returns 27 for an all-zero input.
module fsub_lzc
  import fsub_pkg::*;
(
  input  logic [EXT_W-1:0] din,
  output logic [4:0]       cnt
);

  // scan upward so the highest set bit wins
  always_comb begin
    cnt = 5'(EXT_W);
    for (int i = 0; i < EXT_W; i++)
      if (din[i]) cnt = 5'(EXT_W - 1 - i);
  end

endmodule

// File: rtl/fsub.sv
// Two-stage binary32 subtractor y = x1 - x2, round-to-nearest-even,
// denormals flushed to zero on input and output.
module fsub
  import fsub_pkg::*;
(
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic [31:0] y,
  output logic        ovf,
  input  logic        clk,
  input  logic        rstn
);

  // x2's sign is inverted up front so the datapath only adds signed magnitudes
  logic              sa, sb;
  logic [EXP_W-1:0]  e1, e2;
  logic [MAN_W-1:0]  m1, m2;
  logic              inf1, inf2, nan_in;

  assign sa     = x1[31];
  assign sb     = ~x2[31];
  assign e1     = x1[30:23];
  assign e2     = x2[30:23];
  assign m1     = x1[22:0];
  assign m2     = x2[22:0];
  assign inf1   = (e1 == EXP_MAX) && (m1 == '0);
  assign inf2   = (e2 == EXP_MAX) && (m2 == '0);
  assign nan_in = ((e1 == EXP_MAX) && (m1 != '0)) || ((e2 == EXP_MAX) && (m2 != '0));

  logic [30:0]      mag1, mag2;
  logic             swap, sgn_b, eff_sub;
  logic [EXP_W-1:0] exp_b, exp_s, dexp;
  logic [SIG_W-1:0] sig_b, sig_s;
  logic [EXT_W-1:0] ext_s, al;
  s1_t              s1_d, s1_q;

  // stage 1: magnitude compare, swap, sticky alignment, add/subtract
  always_comb begin
    mag1    = (e1 == '0) ? '0 : x1[30:0];
    mag2    = (e2 == '0) ? '0 : x2[30:0];
    swap    = mag2 > mag1;
    sgn_b   = swap ? sb : sa;
    exp_b   = swap ? mag2[30:23] : mag1[30:23];
    exp_s   = swap ? mag1[30:23] : mag2[30:23];
    sig_b   = swap ? {|mag2[30:23], mag2[22:0]} : {|mag1[30:23], mag1[22:0]};
    sig_s   = swap ? {|mag1[30:23], mag1[22:0]} : {|mag2[30:23], mag2[22:0]};
    eff_sub = sa ^ sb;
    dexp    = exp_b - exp_s;
    ext_s   = {sig_s, 3'b000};
    if (dexp >= 8'd27) begin
      // fully shifted out: only the sticky survives
      al = {26'd0, |sig_s};
    end else begin
      al    = ext_s >> dexp;
      al[0] = al[0] | (|(ext_s & ~({EXT_W{1'b1}} << dexp)));
    end
    s1_d         = '0;
    s1_d.sgn     = sgn_b;
    s1_d.eff_sub = eff_sub;
    s1_d.exp     = exp_b;
    s1_d.sum     = eff_sub ? ({1'b0, sig_b, 3'b000} - {1'b0, al})
                           : ({1'b0, sig_b, 3'b000} + {1'b0, al});
    s1_d.nan     = nan_in | (inf1 & inf2 & eff_sub);
    s1_d.inf     = inf1 | inf2;
    s1_d.inf_s   = inf1 ? sa : sb;
  end

  // stage 1 register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) s1_q <= '0;
    else       s1_q <= s1_d;
  end

  logic [4:0]        lz;
  logic [EXT_W-1:0]  norm;
  logic signed [9:0] exp_n, exp_f;
  logic              rup;
  logic [SIG_W:0]    rnd;
  logic [MAN_W-1:0]  man_f;
  logic [31:0]       y_d;
  logic              ovf_d;

  fsub_lzc u_lzc (
    .din (s1_q.sum[EXT_W-1:0]),
    .cnt (lz)
  );

  // stage 2: normalize, round to nearest even, pick special results
  always_comb begin
    if (s1_q.sum[EXT_W]) begin
      norm    = s1_q.sum[EXT_W:1];
      norm[0] = s1_q.sum[1] | s1_q.sum[0];
      exp_n   = $signed({2'b00, s1_q.exp}) + 10'sd1;
    end else begin
      norm    = s1_q.sum[EXT_W-1:0] << lz;
      exp_n   = $signed({2'b00, s1_q.exp}) - $signed({5'd0, lz});
    end
    rup   = norm[2] & (norm[1] | norm[0] | norm[3]);
    rnd   = {1'b0, norm[26:3]} + {24'd0, rup};
    exp_f = exp_n + (rnd[24] ? 10'sd1 : 10'sd0);
    man_f = rnd[24] ? rnd[23:1] : rnd[22:0];
    y_d   = {s1_q.sgn, exp_f[7:0], man_f};
    ovf_d = 1'b0;
    if (s1_q.nan)
      y_d = QNAN;
    else if (s1_q.inf)
      y_d = s1_q.inf_s ? NINF : PINF;
    else if (s1_q.sum == '0)
      // exact cancellation gives +0; only -0 + -0 keeps a negative zero
      y_d = {~s1_q.eff_sub & s1_q.sgn, 31'd0};
    else if (exp_n <= 10'sd0)
      y_d = {s1_q.sgn, 31'd0};
    else if (exp_f >= 10'sd255) begin
      y_d   = s1_q.sgn ? NINF : PINF;
      ovf_d = 1'b1;
    end
  end

  // output register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      y   <= '0;
      ovf <= 1'b0;
    end else begin
      y   <= y_d;
      ovf <= ovf_d;
    end
  end

endmodule

// File: tb/tb_fsub.sv
// Self-checking bench for fsub: directed corner vectors plus a random
// back-to-back stream compared against a real-arithmetic reference.
module tb_fsub;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] x1 = '0;
  logic [31:0] x2 = '0;
  logic [31:0] y;
  logic        ovf;
  int          checks = 0;
  int          errors = 0;

  fsub dut (.x1(x1), .x2(x2), .y(y), .ovf(ovf), .clk(clk), .rstn(rstn));

  always #5 clk = ~clk;

  localparam int K_NAN = 0, K_INF = 1, K_OVF = 2, K_ZERO = 3, K_FIN = 4;

  localparam int ND = 22;
  localparam logic [31:0] DA [ND] = '{
    32'h40400000, 32'h3F800000, 32'h7F7FFFFF, 32'h3F800000, 32'h00000001, 32'h7F800000,
    32'h3F800000, 32'h7F800000, 32'hFF800000, 32'h4F800000, 32'h3F800000, 32'h3F800001,
    32'h4B800000, 32'h80000000, 32'h00800001, 32'h00800000, 32'h7F7FFFFF, 32'h7F7FFFFF,
    32'hC0400000, 32'hFF800000, 32'h3F800000, 32'hFF7FFFFF};
  localparam logic [31:0] DB [ND] = '{
    32'h3F800000, 32'h3F800000, 32'hFF7FFFFF, 32'h33800000, 32'h00000000, 32'h3F800000,
    32'h7F800000, 32'h7F800000, 32'h7F800000, 32'h3F800000, 32'hB3800000, 32'hB3800000,
    32'h3F800000, 32'h00000000, 32'h00800000, 32'h00800001, 32'hF3000000, 32'h73000000,
    32'hC0400000, 32'hFF7FFFFF, 32'hBF800000, 32'h7F7FFFFF};
  localparam logic [31:0] DY [ND] = '{
    32'h40000000, 32'h00000000, 32'h7F800000, 32'h3F7FFFFF, 32'h00000000, 32'h7F800000,
    32'hFF800000, 32'h7FC00000, 32'hFF800000, 32'h4F800000, 32'h3F800000, 32'h3F800002,
    32'h4B7FFFFF, 32'h80000000, 32'h00000000, 32'h80000000, 32'h7F800000, 32'h7F7FFFFE,
    32'h00000000, 32'hFF800000, 32'h40000000, 32'hFF800000};
  localparam logic DO [ND] = '{
    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  function automatic real rabs(input real v);
    return (v < 0.0) ? -v : v;
  endfunction

  // value of a binary32 pattern, exponent-0 inputs read as zero
  function automatic real to_real(input logic [31:0] b);
    if (b[30:23] == 8'd0) return 0.0;
    return $bitstoreal({b[31], 11'(int'(b[30:23]) + 896), b[22:0], 29'd0});
  endfunction

  // reference: classify x1 - x2 and give the exact difference for finite cases
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output int kind, output logic sgn, output real r);
    logic na, nb, ia, ib, sa, sn;
    real  ar;
    na = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    nb = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    ia = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    ib = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    sa = a[31];
    sn = ~b[31];
    r = 0.0;
    sgn = 1'b0;
    kind = K_FIN;
    if (na || nb || (ia && ib && (sa != sn))) kind = K_NAN;
    else if (ia) begin kind = K_INF; sgn = sa; end
    else if (ib) begin kind = K_INF; sgn = sn; end
    else begin
      r = to_real(a) - to_real(b);
      ar = rabs(r);
      sgn = (r < 0.0);
      // halfway between max finite and 2^128 already rounds to infinity
      if (ar >= $bitstoreal(64'h47F0000000000000) - $bitstoreal(64'h4660000000000000))
        kind = K_OVF;
      else if (ar < $bitstoreal(64'h3810000000000000))
        kind = K_ZERO;
    end
  endfunction

  function automatic logic [7:0] rnd_exp();
    int cls;
    cls = int'($urandom_range(0, 15));
    if (cls == 0) return 8'h00;
    if (cls == 1) return 8'hFF;
    return 8'($urandom_range(1, 254));
  endfunction

  function automatic logic [31:0] gen_fp(input logic [7:0] e);
    logic [22:0] m;
    m = (e == 8'h00 || e == 8'hFF) ? 23'd0 : 23'($urandom);
    return {1'($urandom), e, m};
  endfunction

  task automatic test_reset();
    rstn = 1'b0;
    x1 = 32'h7F7FFFFF;
    x2 = 32'hFF7FFFFF;
    #2;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (y !== 32'd0 || ovf !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: y=%h ovf=%b, want y=00000000 ovf=0", i, y, ovf);
      end
    end
    #3 rstn = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    checks++;
    if (y !== 32'h7F800000 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL first_after_reset: y=%h ovf=%b, want y=7F800000 ovf=1", y, ovf);
    end
  endtask

  task automatic test_latency();
    @(posedge clk); #1;
    x1 = 32'h0; x2 = 32'h0;
    @(posedge clk);
    @(posedge clk); #1;
    x1 = 32'h40400000; x2 = 32'h3F800000;
    @(posedge clk); #1;
    checks++;
    if (y !== 32'h0) begin
      errors++;
      $display("FAIL latency_early: y=%h after one edge, want 00000000", y);
    end
    @(posedge clk); #1;
    checks++;
    if (y !== 32'h40000000 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL latency_two: y=%h ovf=%b, want y=40000000 ovf=0", y, ovf);
    end
    x1 = 32'h7F7FFFFF; x2 = 32'hFF7FFFFF;
    #3;
    checks++;
    if (y !== 32'h40000000 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL hold_between_edges: y=%h ovf=%b, want y=40000000 ovf=0", y, ovf);
    end
  endtask

  task automatic test_directed();
    for (int i = 0; i < ND; i++) begin
      @(posedge clk); #1;
      x1 = DA[i]; x2 = DB[i];
      @(posedge clk);
      @(posedge clk); #1;
      checks++;
      if (y !== DY[i] || ovf !== DO[i]) begin
        errors++;
        $display("FAIL directed[%0d] %h-%h: y=%h ovf=%b, want y=%h ovf=%b",
                 i, DA[i], DB[i], y, ovf, DY[i], DO[i]);
      end
    end
  endtask

  task automatic test_nan();
    logic [31:0] na [4] = '{32'h7FC00001, 32'h3F800000, 32'h7F800001, 32'h7FFFFFFF};
    logic [31:0] nb [4] = '{32'h3F800000, 32'hFFC00000, 32'h7F800000, 32'h00000000};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      x1 = na[i]; x2 = nb[i];
      @(posedge clk);
      @(posedge clk); #1;
      checks++;
      if (y[30:23] !== 8'hFF || y[22:0] == 23'd0 || ovf !== 1'b0) begin
        errors++;
        $display("FAIL nan[%0d] %h-%h: y=%h ovf=%b, want a NaN with ovf=0", i, na[i], nb[i], y, ovf);
      end
    end
  endtask

  task automatic test_back_to_back(input int n);
    logic [63:0] q[$];
    logic [63:0] pr, rb;
    logic [31:0] a, b, pa, pb;
    int          kind, mode, t, ex;
    logic        sgn, ok;
    real         r, ulp;
    for (int i = 0; i < n + 2; i++) begin
      @(posedge clk); #1;
      if (q.size() == 2) begin
        pr = q.pop_front();
        pa = pr[63:32];
        pb = pr[31:0];
        model(pa, pb, kind, sgn, r);
        case (kind)
          K_NAN:  ok = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0) && !ovf;
          K_INF:  ok = (y == {sgn, 8'hFF, 23'd0}) && !ovf;
          K_OVF:  ok = (y == {sgn, 8'hFF, 23'd0}) && ovf;
          K_ZERO: ok = (y[30:0] == 31'd0) && !ovf && (pa != pb || y == 32'd0);
          default: begin
            rb  = $realtobits(rabs(r));
            ex  = int'(rb[62:52]) - 1023;
            ulp = $bitstoreal({1'b0, 11'(ex + 1000), 52'd0});
            ok  = !ovf && (y[30:23] != 8'h00) && (y[30:23] != 8'hFF) &&
                  (rabs(to_real(y) - r) <= ulp);
          end
        endcase
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL random[%0d] %h-%h: y=%h ovf=%b, want class %0d sign %b value %g",
                   i, pa, pb, y, ovf, kind, sgn, r);
        end
      end
      mode = int'($urandom_range(0, 7));
      case (mode)
        3, 4: begin
          a = gen_fp(8'($urandom_range(1, 254)));
          t = int'(a[30:23]) + int'($urandom_range(0, 4)) - 2;
          if (t < 1) t = 1;
          if (t > 254) t = 254;
          b = {1'($urandom), 8'(t), a[22:0] ^ 23'($urandom_range(0, 255))};
        end
        5: begin
          a = gen_fp(8'($urandom_range(1, 254)));
          b = {1'($urandom), a[30:0]};
        end
        6: begin
          a = gen_fp(8'($urandom_range(250, 254)));
          b = gen_fp(8'($urandom_range(250, 254)));
        end
        7: begin
          a = gen_fp(8'($urandom_range(1, 4)));
          b = gen_fp(8'($urandom_range(1, 4)));
        end
        default: begin
          a = gen_fp(rnd_exp());
          b = gen_fp(rnd_exp());
        end
      endcase
      x1 = a; x2 = b;
      q.push_back({a, b});
    end
  endtask

  task automatic test_reset_midstream();
    @(posedge clk); #1;
    x1 = 32'h7F7FFFFF; x2 = 32'hFF7FFFFF;
    @(posedge clk); #1;
    x1 = 32'h40400000; x2 = 32'h3F800000;
    @(posedge clk); #1;
    checks++;
    if (y !== 32'h7F800000 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: y=%h ovf=%b, want y=7F800000 ovf=1", y, ovf);
    end
    #1 rstn = 1'b0;
    x1 = 32'h40400000; x2 = 32'hBF800000;
    #1;
    checks++;
    if (y !== 32'h0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL async_clear: y=%h ovf=%b, want y=00000000 ovf=0", y, ovf);
    end
    @(posedge clk);
    #3 rstn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (y !== 32'h0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL inflight_discard: y=%h ovf=%b, want y=00000000 ovf=0", y, ovf);
    end
    @(posedge clk); #1;
    checks++;
    if (y !== 32'h40800000 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_result: y=%h ovf=%b, want y=40800000 ovf=0", y, ovf);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_nan();
    test_back_to_back(4000);
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
